alu_seq: RTL and testbench

//  Parametrised, handshaked ALU that succeeds the single-width combinational add/sub/and/notB unit.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_mul_iter.sv | 61 ++++++
 rtl/alu_seq.sv | 169 ++++++++++++++++
 tb/tb_alu_seq.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the handshaked sequential ALU.
//   - op encodings presented on the op port
//   - controller state encoding
//   - bit positions of {N,Z,C,V} inside the flags bus
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_NOTB = 3'b011,
        OP_OR   = 3'b100,
        OP_XOR  = 3'b101,
        OP_SHL  = 3'b110,
        OP_MUL  = 3'b111
    } alu_op_e;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        MUL_BUSY = 1'b1
    } alu_state_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: iterative unsigned shift-add multiplier.
//   clk, reset   clock, asynchronous active-high reset
//   i_start      load operands and begin (ignored while running)
//   i_a, i_b     multiplicand / multiplier, WIDTH bits
//   o_done       high during the final iteration cycle
//   o_product    2*WIDTH product, valid while o_done is high
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_start,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    output logic                 o_done,
    output logic [2*WIDTH-1:0]   o_product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic               r_busy;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] w_acc_nxt;

    assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);

    // The last partial product is folded in combinationally so the
    // caller can register the full product on the final iteration edge.
    assign o_done    = r_busy && (r_cnt == CW'(1));
    assign o_product = w_acc_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
        end else if (i_start && !r_busy) begin
            r_busy   <= 1'b1;
            r_cnt    <= CW'(WIDTH);
            r_mcand  <= {{WIDTH{1'b0}}, i_a};
            r_mplier <= i_b;
            r_acc    <= '0;
        end else if (r_busy) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: valid/ready ALU with registered result, {N,Z,C,V} flags and a
// sticky overflow bit.
//   clk, reset             clock, asynchronous active-high reset
//   in_valid/in_ready      operation handshake (op, ain, bin)
//   out_valid/out_ready    result handshake (result, flags)
//   busy                   multiply in progress
//   ovf_sticky/clr_sticky  sticky V of delivered results / synchronous clear
//
// state    | meaning
// IDLE     | single-cycle ops accepted whenever the output slot is free
// MUL_BUSY | iterative multiply running; no new operation accepted
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int ENABLE_MUL = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] ain,
    input  logic [WIDTH-1:0] bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             busy,
    output logic             ovf_sticky,
    input  logic             clr_sticky
);

    localparam int SW = $clog2(WIDTH);

    alu_state_e         r_state, w_state_nxt;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_result;
    logic [3:0]         r_flags;
    logic               r_ovf_sticky;

    logic               w_in_ready, w_busy;
    logic               w_accept, w_xfer, w_is_mul, w_single, w_mul_start;
    logic               w_mul_done;
    logic [2*WIDTH-1:0] w_product;
    logic [WIDTH:0]     w_sum, w_shl;
    logic [WIDTH-1:0]   w_res;
    logic               w_c, w_v;
    logic [3:0]         w_flags, w_mul_flags;

    assign w_accept    = in_valid && w_in_ready;
    assign w_xfer      = r_out_valid && out_ready;
    assign w_is_mul    = (op == OP_MUL) && (ENABLE_MUL != 0);
    assign w_single    = w_accept && !w_is_mul;
    assign w_mul_start = w_accept && w_is_mul;

    generate
        if (ENABLE_MUL != 0) begin : g_mul
            alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
                .clk       (clk),
                .reset     (reset),
                .i_start   (w_mul_start),
                .i_a       (ain),
                .i_b       (bin),
                .o_done    (w_mul_done),
                .o_product (w_product)
            );
        end else begin : g_no_mul
            assign w_mul_done = 1'b0;
            assign w_product  = '0;
        end
    endgenerate

    // Single-cycle datapath; MUL with the multiplier disabled yields 0.
    always_comb begin
        w_sum = '0;
        w_shl = '0;
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (op)
            OP_ADD: begin
                w_sum = {1'b0, ain} + {1'b0, bin};
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (ain[WIDTH-1] ^ bin[WIDTH-1] ^ w_sum[WIDTH-1]) ^ w_sum[WIDTH];
            end
            OP_SUB: begin
                w_sum = {1'b0, ain} + {1'b0, ~bin} + {{WIDTH{1'b0}}, 1'b1};
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (ain[WIDTH-1] ^ ~bin[WIDTH-1] ^ w_sum[WIDTH-1]) ^ w_sum[WIDTH];
            end
            OP_AND:  w_res = ain & bin;
            OP_NOTB: w_res = ~bin;
            OP_OR:   w_res = ain | bin;
            OP_XOR:  w_res = ain ^ bin;
            OP_SHL: begin
                // Shifting a WIDTH+1 vector leaves A[WIDTH-s] in the top bit.
                w_shl = {1'b0, ain} << bin[SW-1:0];
                w_res = w_shl[WIDTH-1:0];
                w_c   = w_shl[WIDTH];
            end
            default: w_res = '0;
        endcase
    end

    assign w_flags     = {w_res[WIDTH-1], (w_res == '0), w_c, w_v};
    assign w_mul_flags = {w_product[WIDTH-1], (w_product[WIDTH-1:0] == '0),
                          1'b0, (w_product[2*WIDTH-1:WIDTH] != '0)};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:     if (w_mul_start) w_state_nxt = MUL_BUSY;
            MUL_BUSY: if (w_mul_done)  w_state_nxt = IDLE;
            default:  w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_in_ready = (r_state == IDLE) && (!r_out_valid || out_ready);
        w_busy     = (r_state == MUL_BUSY);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_flags     <= '0;
        end else if (w_single) begin
            r_out_valid <= 1'b1;
            r_result    <= w_res;
            r_flags     <= w_flags;
        end else if (w_mul_done) begin
            r_out_valid <= 1'b1;
            r_result    <= w_product[WIDTH-1:0];
            r_flags     <= w_mul_flags;
        end else if (w_xfer) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovf_sticky <= 1'b0;
        end else if (w_xfer && r_flags[FLAG_V]) begin
            r_ovf_sticky <= 1'b1;
        end else if (clr_sticky) begin
            r_ovf_sticky <= 1'b0;
        end
    end

    assign in_ready   = w_in_ready;
    assign busy       = w_busy;
    assign out_valid  = r_out_valid;
    assign result     = r_result;
    assign flags      = r_flags;
    assign ovf_sticky = r_ovf_sticky;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
    import alu_pkg::*;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic         clr_sticky = 1'b0;
    logic [2:0]   op = 3'b000;
    logic [W-1:0] ain = '0;
    logic [W-1:0] bin = '0;
    logic         in_ready, out_valid, busy, ovf_sticky;
    logic [W-1:0] result;
    logic [3:0]   flags;

    int n_tests = 0;
    int n_fail  = 0;

    alu_seq #(.WIDTH(W), .ENABLE_MUL(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .ain        (ain),
        .bin        (bin),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .flags      (flags),
        .busy       (busy),
        .ovf_sticky (ovf_sticky),
        .clr_sticky (clr_sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Entered and left on a negedge; the result transfers on the following posedge.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] er, input logic [3:0] ef);
        op = o; ain = a; bin = b; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; ain = ~a; bin = ~b;
        chk({tag, ".vld"}, 32'(out_valid), 32'd1);
        chk({tag, ".res"}, 32'(result), 32'(er));
        chk({tag, ".flg"}, 32'(flags), 32'(ef));
    endtask

    task automatic run_mul(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] er, input logic [3:0] ef);
        int bad;
        bad = 0;
        op = OP_MUL; ain = a; bin = b; in_valid = 1'b1;
        for (int i = 1; i <= W; i++) begin
            @(negedge clk);
            in_valid = 1'b0; ain = ~a; bin = a ^ b;
            if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
        end
        chk({tag, ".during"}, 32'(bad), 32'd0);
        @(negedge clk);
        chk({tag, ".vld"},  32'(out_valid), 32'd1);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        chk({tag, ".res"},  32'(result), 32'(er));
        chk({tag, ".flg"},  32'(flags), 32'(ef));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int hold_bad;
        int late_bad;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst.vld",    32'(out_valid), 32'd0);
        chk("rst.res",    32'(result), 32'd0);
        chk("rst.flg",    32'(flags), 32'd0);
        chk("rst.busy",   32'(busy), 32'd0);
        chk("rst.sticky", 32'(ovf_sticky), 32'd0);
        chk("rst.rdy",    32'(in_ready), 32'd1);
        @(negedge clk);

        // flags = {N,Z,C,V}
        run_op("add_ovf", OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 4'b1001);
        @(negedge clk);
        chk("add_ovf.sticky", 32'(ovf_sticky), 32'd1);
        clr_sticky = 1'b1;
        @(negedge clk);
        clr_sticky = 1'b0;
        chk("clr.sticky", 32'(ovf_sticky), 32'd0);

        run_op("sub_borrow", OP_SUB,  16'h0000, 16'h0001, 16'hFFFF, 4'b1000);
        run_op("sub_zero",   OP_SUB,  16'h0005, 16'h0005, 16'h0000, 4'b0110);
        run_op("shl_1",      OP_SHL,  16'h8001, 16'h0001, 16'h0002, 4'b0010);
        run_op("notb",       OP_NOTB, 16'h1234, 16'h00FF, 16'hFF00, 4'b1000);
        run_op("and",        OP_AND,  16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000);
        run_op("or",         OP_OR,   16'hF000, 16'h000F, 16'hF00F, 4'b1000);
        run_op("xor",        OP_XOR,  16'hAAAA, 16'hAAAA, 16'h0000, 4'b0100);
        run_op("add_carry",  OP_ADD,  16'hFFFF, 16'h0001, 16'h0000, 4'b0110);
        run_op("shl_15",     OP_SHL,  16'h0001, 16'h000F, 16'h8000, 4'b1000);
        run_op("shl_0",      OP_SHL,  16'h1234, 16'h0010, 16'h1234, 4'b0000);
        run_op("sub_vneg",   OP_SUB,  16'h8000, 16'h0001, 16'h7FFF, 4'b0011);
        @(negedge clk);

        run_mul("mul_256", 16'h0100, 16'h0100, 16'h0000, 4'b0101);
        run_mul("mul_3",   16'h1234, 16'h0003, 16'h369C, 4'b0000);
        run_mul("mul_max", 16'hFFFF, 16'hFFFF, 16'h0001, 4'b0001);
        @(negedge clk);
        chk("mul_max.sticky", 32'(ovf_sticky), 32'd1);

        // Backpressure: pending ADD held for 5 cycles, next op waits.
        out_ready = 1'b0;
        run_op("bp_add", OP_ADD, 16'h1111, 16'h2222, 16'h3333, 4'b0000);
        op = OP_ADD; ain = 16'h0001; bin = 16'h0001; in_valid = 1'b1;
        hold_bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || result !== 16'h3333 || in_ready !== 1'b0) hold_bad++;
        end
        chk("bp.hold", 32'(hold_bad), 32'd0);
        out_ready = 1'b1;
        #1;
        chk("bp.release_rdy", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp.next_vld", 32'(out_valid), 32'd1);
        chk("bp.next_res", 32'(result), 32'h0002);
        @(negedge clk);

        // Reset in the 8th cycle of a multiply.
        op = OP_MUL; ain = 16'h0100; bin = 16'h0100; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        chk("rmul.busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("rmul.vld",    32'(out_valid), 32'd0);
        chk("rmul.busy",   32'(busy), 32'd0);
        chk("rmul.sticky", 32'(ovf_sticky), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_op("post_rst", OP_ADD, 16'h0002, 16'h0003, 16'h0005, 4'b0000);
        late_bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || busy !== 1'b0) late_bad++;
        end
        chk("rmul.no_late_result", 32'(late_bad), 32'd0);

        // Set and clear in the same cycle: set wins.
        run_op("set_clr", OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 4'b1001);
        clr_sticky = 1'b1;
        @(negedge clk);
        clr_sticky = 1'b0;
        chk("set_clr.sticky", 32'(ovf_sticky), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
